// File: rtl/seq_multiplier_4_bit_if.sv
// Operand/result bundle for the 4x4 sequential multiplier.
// The master drives start and the operands; the slave returns busy/done/product.
interface seq_multiplier_4_bit_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 2 * OP_W;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input product);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output product);
endinterface

// File: rtl/seq_multiplier_4_bit.sv
// 4x4 unsigned shift-and-add multiplier built around one reused ripple adder.
// A result appears 5 cycles after start is accepted; one operation every 6 cycles.

module adder_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic carry;

  // Ripple carry chain, LSB first
  always_comb begin
    carry = 1'b0;
    s_o   = '0;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end
endmodule

module seq_multiplier_4_bit (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_multiplier_4_bit_if.slave bus
);
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     m_q, m_d;
  logic [OP_W-1:0]     q_q, q_d;
  logic [OP_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [OP_W-1:0]     sum_s;
  logic                sum_c;

  adder_4_bit u_adder (
    .a_i (acc_q),
    .b_i (m_q),
    .s_o (sum_s),
    .c_o (sum_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry of the partial-product add shifts into acc[3]
        if (q_q[0]) begin
          {acc_d, q_d} = {sum_c, sum_s, q_q[OP_W-1:1]};
        end else begin
          {acc_d, q_d} = {1'b0, acc_q, q_q[OP_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(3)) begin
          product_d = {acc_d, q_d};
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_multiplier_4_bit.sv
// Directed self-checking bench for seq_multiplier_4_bit: vector table plus
// hand-written sequences for busy-start, back-to-back and mid-operation reset.
module tb_seq_multiplier_4_bit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_multiplier_4_bit_if mif ();

  seq_multiplier_4_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full operation from IDLE; checks busy profile, done latency, product and return to idle
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string nm);
    int lat;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    mif.a = a; mif.b = b; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    mif.a = ~a; mif.b = ~b;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (mif.busy !== 1'b1) busy_ok = 1'b0;
      if (mif.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({nm, " busy"}, 32'(busy_ok), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'd5);
    chk({nm, " product"}, 32'(mif.product), 32'(exp));
    @(negedge clk);
    chk({nm, " idle"}, {30'd0, mif.busy, mif.done}, 32'd0);
    chk({nm, " hold"}, 32'(mif.product), 32'(exp));
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    logic [7:0] p1;
    logic [7:0] p2;

    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;

    vecs[0] = '{4'd7,  4'd3,  8'h15};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd9,  8'h00};
    vecs[3] = '{4'd9,  4'd0,  8'h00};
    vecs[4] = '{4'd1,  4'd15, 8'h0F};
    vecs[5] = '{4'd12, 4'd11, 8'h84};
    vecs[6] = '{4'd8,  4'd8,  8'h40};
    vecs[7] = '{4'd5,  4'd13, 8'h41};

    // Reset with clock running
    repeat (3) @(negedge clk);
    chk("reset outputs", {22'd0, mif.busy, mif.done, mif.product}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle no start %0d", k), {22'd0, mif.busy, mif.done, mif.product}, 32'd0);
    end

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));

    // Product holds across idle and is not cleared on a new start
    repeat (3) @(negedge clk);
    chk("idle hold", 32'(mif.product), 32'h41);
    @(negedge clk);
    mif.a = 4'd2; mif.b = 4'd2; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    chk("not cleared on start", 32'(mif.product), 32'h41);
    repeat (6) @(negedge clk);
    chk("2x2 product", 32'(mif.product), 32'h04);

    // Start while busy and in DONE is ignored
    done_cnt = 0;
    @(negedge clk);
    mif.a = 4'd5; mif.b = 4'd5; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin mif.start = 1'b1; mif.a = 4'd2; mif.b = 4'd2; end
      if (mif.done === 1'b1) begin
        done_cnt++;
        chk("busy-start done cycle", 32'(k), 32'd5);
        chk("busy-start product", 32'(mif.product), 32'h19);
      end
      if (k == 6) mif.start = 1'b0;
      if (k >= 6) chk($sformatf("busy-start no rerun %0d", k), 32'(mif.busy), 32'd0);
    end
    chk("busy-start done count", 32'(done_cnt), 32'd1);
    chk("busy-start final product", 32'(mif.product), 32'h19);

    // Back-to-back with start held high
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    p1 = '0;
    p2 = '0;
    @(negedge clk);
    mif.a = 4'd3; mif.b = 4'd4; mif.start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin mif.a = 4'd6; mif.b = 4'd7; end
      if (k == 7) mif.start = 1'b0;
      if (mif.done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin first_done = k; p1 = mif.product; end
        if (done_cnt == 2) begin second_done = k; p2 = mif.product; end
      end
    end
    chk("b2b done count", 32'(done_cnt), 32'd2);
    chk("b2b first latency", 32'(first_done), 32'd5);
    chk("b2b spacing", 32'(second_done - first_done), 32'd6);
    chk("b2b product1", 32'(p1), 32'h0C);
    chk("b2b product2", 32'(p2), 32'h2A);
    chk("b2b idle after", {30'd0, mif.busy, mif.done}, 32'd0);

    // Asynchronous reset in the third RUN cycle
    @(negedge clk);
    mif.a = 4'd15; mif.b = 4'd15; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", 32'(mif.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-op reset outputs", {22'd0, mif.busy, mif.done, mif.product}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mif.done === 1'b1 || mif.busy === 1'b1) done_cnt++;
    end
    chk("no done after reset", 32'(done_cnt), 32'd0);
    do_op(4'd2, 4'd3, 8'h06, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
